// File: rtl/sorter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sorter_pkg
//  Description : Shared types and helpers for the seq_sorter block:
//                FSM state encoding and the index-width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sorter_pkg;

    // Two bits are enough for three states; encodings are fixed explicitly.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bits needed to index 0..n-1; never less than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : sorter_pkg
`default_nettype wire

// File: rtl/seq_sorter_cmpx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_sorter_cmpx
//  Description : One combinational compare-exchange cell. Swaps only when
//                the pair is strictly out of order, so equal values keep
//                their relative order.
//  Ports       : a, b  - left / right element of the pair
//                dir   - 0 = ascending, 1 = descending
//                lo    - value for the left position
//                hi    - value for the right position
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_sorter_cmpx #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             dir,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic w_swap;

    // Unsigned compare over the full width.
    assign w_swap = dir ? (a < b) : (a > b);
    assign lo     = w_swap ? b : a;
    assign hi     = w_swap ? a : b;

endmodule : seq_sorter_cmpx
`default_nettype wire

// File: rtl/seq_sorter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_sorter
//  Description : Batch sorter. Loads N elements through a valid/ready input,
//                sorts them in N cycles of odd-even transposition, then
//                drains them in order through a valid/ready output.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - input handshake, in_data element
//                out_valid/out_ready - output handshake, out_data element
//                out_last            - marks the Nth output element
//                busy                - high while sorting or draining
//                desc                - (SEQ_SORTER_DESCEND_EN only) 1 sorts
//                                      the batch descending, sampled on the
//                                      first element of the batch
//  Config      : `define SEQ_SORTER_DESCEND_EN to add the desc port.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_sorter
    import sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
`ifdef SEQ_SORTER_DESCEND_EN
    input  logic             desc,
`endif
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int                 c_IDX_W = idx_w(N);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] r_cnt;     // load slot index
    logic [c_IDX_W-1:0] r_k;       // sort round index
    logic [c_IDX_W-1:0] r_idx;     // drain index
    logic [WIDTH-1:0]   r_slot   [N];
    logic [WIDTH-1:0]   w_sorted [N];
    logic [WIDTH-1:0]   w_lo     [N-1];
    logic [WIDTH-1:0]   w_hi     [N-1];
    logic               w_dir;
    logic               w_in_hs;
    logic               w_out_hs;

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

`ifdef SEQ_SORTER_DESCEND_EN
    logic r_desc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_desc <= 1'b0;
        end else if (w_in_hs && (r_cnt == '0)) begin
            r_desc <= desc;
        end
    end

    assign w_dir = r_desc;
`else
    assign w_dir = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:  if (w_in_hs && (r_cnt == c_LAST))  w_state_nxt = ST_SORT;
            ST_SORT:  if (r_k == c_LAST)                 w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_hs && (r_idx == c_LAST)) w_state_nxt = ST_LOAD;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign out_valid = (r_state == ST_DRAIN);
    assign busy      = (r_state != ST_LOAD);
    assign out_last  = (r_state == ST_DRAIN) && (r_idx == c_LAST);
    assign out_data  = (r_state == ST_DRAIN) ? r_slot[r_idx] : '0;

    // ------------------------------------------------------------------
    // Counters; each wraps to zero at its last value so the next batch
    // starts clean without extra clearing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_k   <= '0;
            r_idx <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_k <= '0;
                    if (w_in_hs) begin
                        r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                ST_SORT: begin
                    r_k <= (r_k == c_LAST) ? '0 : r_k + 1'b1;
                end
                ST_DRAIN: begin
                    if (w_out_hs) begin
                        r_idx <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_k   <= '0;
                    r_idx <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Compare-exchange network: one cell per adjacent pair. Each round
    // only the pairs whose left index matches the round parity are used.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N - 1; i++) begin : g_cmpx
        seq_sorter_cmpx #(
            .WIDTH (WIDTH)
        ) u_cmpx (
            .a   (r_slot[i]),
            .b   (r_slot[i+1]),
            .dir (w_dir),
            .lo  (w_lo[i]),
            .hi  (w_hi[i])
        );
    end

    // Slot j is the left member of pair j when j matches the round parity,
    // otherwise it is the right member of pair j-1 (if those pairs exist).
    for (genvar j = 0; j < N; j++) begin : g_sel
        localparam logic c_PAR = 1'(j % 2);
        if (j == 0) begin : g_first
            assign w_sorted[j] = (r_k[0] == c_PAR) ? w_lo[j] : r_slot[j];
        end else if (j == N - 1) begin : g_last
            assign w_sorted[j] = (r_k[0] != c_PAR) ? w_hi[j-1] : r_slot[j];
        end else begin : g_mid
            assign w_sorted[j] = (r_k[0] == c_PAR) ? w_lo[j] : w_hi[j-1];
        end
    end

    // Slot storage carries no reset; a discarded batch is simply
    // overwritten by the next load.
    for (genvar j = 0; j < N; j++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst) begin
                if (r_state == ST_SORT) begin
                    r_slot[j] <= w_sorted[j];
                end else if (w_in_hs && (r_cnt == c_IDX_W'(j))) begin
                    r_slot[j] <= in_data;
                end
            end
        end
    end

endmodule : seq_sorter
`default_nettype wire
